// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder: one 4-bit nibble per clock, LSB nibble first,
//   carry rippled through a registered carry bit. Valid/ready on both sides.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, c_in         operands and carry-in, sampled on accept
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   sum                registered a+b+c_in modulo 2^WIDTH
//   c_out              carry out of bit WIDTH-1
//   ovf                signed overflow (carry into MSB xor carry out of MSB)
//   busy               high while nibbles are being added
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       nib_sum;
  logic [3:0]       low3_sum;
  logic             last;

  // Current nibble slice and its 5-bit sum.
  always_comb begin
    a_nib    = a_r[idx*4 +: 4];
    b_nib    = b_r[idx*4 +: 4];
    nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
    // Adding only the low three bits exposes the carry into the nibble's
    // top bit; on the last nibble that is the carry into bit WIDTH-1.
    low3_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry};
    last     = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          sum[idx*4 +: 4] <= nib_sum[3:0];
          carry           <= nib_sum[4];
          idx             <= idx + 1'b1;
          if (last) begin
            c_out <= nib_sum[4];
            ovf   <= low3_sum[3] ^ nib_sum[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed cases with fixed
// expected values plus 1000 back-to-back random operations checked against
// a whole-word arithmetic reference. Expected results are queued at accept
// and popped by an independent monitor on each output handshake.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    logic [W:0] t;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one comparison per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_result: got sum=0x%0h, expected no result", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        nvec++;
        if (sum !== e.s || c_out !== e.c || ovf !== e.v) begin
          nerr++;
          $display("FAIL result: got sum=0x%0h c_out=%0b ovf=%0b, expected sum=0x%0h c_out=%0b ovf=%0b",
                   sum, c_out, ovf, e.s, e.c, e.v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait (bounded) for acceptance, queue the expectation.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    c_in     = ci;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
    end
    q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic v);
    exp_t e;
    e.s = s;
    e.c = c;
    e.v = v;
    return e;
  endfunction

  initial begin
    int lat, bc, last_acc, n;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    #12 rst_n = 1'b1;
    step();

    // Basic add with latency and busy-length checks.
    send(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0));
    lat = 1;
    bc  = 1;
    while (!out_valid && lat < 20) begin
      step();
      if (busy) bc++;
      if (!out_valid) lat++;
    end
    check("latency",    32'(lat), 32'd4);
    check("busy_count", 32'(bc),  32'd4);
    wait_idle();

    // Carry ripple and overflow corners.
    send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    wait_idle();
    send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    wait_idle();
    send(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1));
    wait_idle();

    // Input isolation and output backpressure.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0));
    a    = 16'hFFFF;
    b    = 16'hFFFF;
    c_in = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum",       32'(sum),       32'h3333);
      check("bp_c_out",     32'(c_out),     32'd0);
      check("bp_ovf",       32'(ovf),       32'd0);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // Reset two cycles into RUN aborts the operation.
    send(16'hAAAA, 16'h5555, 1'b1, mk(16'h0000, 1'b1, 1'b0));
    step();
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum),       32'd0);
    check("midrst_c_out",     32'(c_out),     32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(16'h0F0F, 16'hF0F0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
    wait_idle();

    // Back-to-back random traffic with in_valid and out_ready held high.
    in_valid = 1'b1;
    last_acc = -1;
    for (int k = 0; k < 1000; k++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      a    = ra;
      b    = rb;
      c_in = rc;
      n = 0;
      while (!in_ready && n < 50) begin
        step();
        n++;
      end
      if (!in_ready) begin
        nvec++;
        nerr++;
        $display("FAIL b2b_accept_timeout: got in_ready=0, expected 1");
      end
      if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'd6);
      last_acc = cyc;
      q.push_back(model(ra, rb, rc));
      step();
    end
    in_valid = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
